// File: rtl/wb_regfile_pkg.sv
// Shared register-file definitions: widths, reset/write polarities and the
// bubble triple loaded into the MEM/WB stages on reset, flush or stall.
package wb_regfile_pkg;

  localparam int RegWidth     = 32;
  localparam int RegAddrWidth = 5;
  localparam int RegNum       = 32;

  localparam logic RstEnable   = 1'b1;
  localparam logic WriteEnable = 1'b1;

  typedef logic [RegWidth-1:0]     RegBus;
  typedef logic [RegAddrWidth-1:0] RegAddrBus;

  localparam RegBus     ZeroWord   = '0;
  localparam RegAddrBus NOPRegAddr = '0;

  typedef struct packed {
    logic      we;
    RegAddrBus addr;
    RegBus     data;
  } wr_triple_t;

  localparam wr_triple_t BubbleTriple = '{we: 1'b0, addr: NOPRegAddr, data: ZeroWord};

endpackage

// File: rtl/wb_regfile_regfile.sv
// General register array with synchronous write, single-cycle reset clear and
// two combinational read ports that bypass the value being written this cycle.
module regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = RegWidth,
  parameter int ADDR_W = RegAddrWidth,
  parameter int NREG   = RegNum
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re1_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic              re2_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata2_o
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic              wr_en;

  assign wr_en = (we_i == WriteEnable) && (waddr_i != ADDR_W'(NOPRegAddr));

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // A write landing this cycle is returned directly so readers never see stale data.
  function automatic logic [DATA_W-1:0] read_port(input logic re, input logic [ADDR_W-1:0] raddr);
    if ((rst == RstEnable) || !re || (raddr == ADDR_W'(NOPRegAddr))) begin
      return DATA_W'(ZeroWord);
    end else if (wr_en && (waddr_i == raddr)) begin
      return wdata_i;
    end else begin
      return regs_q[raddr];
    end
  endfunction

  always_comb begin
    rdata1_o = read_port(re1_i, raddr1_i);
    rdata2_o = read_port(re2_i, raddr2_i);
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back end of the EX result path: MEM and WB pipeline registers feeding
// the register array, with EX/MEM forwarding layered over the array's WB bypass.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = RegWidth,
  parameter int ADDR_W = RegAddrWidth,
  parameter int NREG   = RegNum
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ex_waddr_i,
  input  logic              ex_we_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              re1_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic              re2_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata2_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_waddr_o,
  output logic [DATA_W-1:0] wb_wdata_o
);

  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              wb_we_q,     wb_we_d;
  logic [ADDR_W-1:0] wb_waddr_q,  wb_waddr_d;
  logic [DATA_W-1:0] wb_wdata_q,  wb_wdata_d;
  logic [DATA_W-1:0] rf_rdata1,   rf_rdata2;

  // Flush beats stall: a held MEM entry is discarded rather than kept.
  always_comb begin
    mem_we_d    = mem_we_q;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    if ((rst == RstEnable) || flush_i) begin
      mem_we_d    = BubbleTriple.we;
      mem_waddr_d = ADDR_W'(BubbleTriple.addr);
      mem_wdata_d = DATA_W'(BubbleTriple.data);
    end else if (!stall_i) begin
      mem_we_d    = ex_we_i;
      mem_waddr_d = ex_waddr_i;
      mem_wdata_d = ex_wdata_i;
    end
  end

  always_comb begin
    wb_we_d    = mem_we_q;
    wb_waddr_d = mem_waddr_q;
    wb_wdata_d = mem_wdata_q;
    if ((rst == RstEnable) || flush_i || stall_i) begin
      wb_we_d    = BubbleTriple.we;
      wb_waddr_d = ADDR_W'(BubbleTriple.addr);
      wb_wdata_d = DATA_W'(BubbleTriple.data);
    end
  end

  always_ff @(posedge clk) begin
    mem_we_q    <= mem_we_d;
    mem_waddr_q <= mem_waddr_d;
    mem_wdata_q <= mem_wdata_d;
    wb_we_q     <= wb_we_d;
    wb_waddr_q  <= wb_waddr_d;
    wb_wdata_q  <= wb_wdata_d;
  end

  regfile #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREG   (NREG)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we_i     (wb_we_q),
    .waddr_i  (wb_waddr_q),
    .wdata_i  (wb_wdata_q),
    .re1_i    (re1_i),
    .raddr1_i (raddr1_i),
    .rdata1_o (rf_rdata1),
    .re2_i    (re2_i),
    .raddr2_i (raddr2_i),
    .rdata2_o (rf_rdata2)
  );

  // Youngest producer first: EX, then MEM, then whatever the array port resolved.
  function automatic logic [DATA_W-1:0] forward(input logic re, input logic [ADDR_W-1:0] raddr,
                                                input logic [DATA_W-1:0] rf_data);
    if ((rst == RstEnable) || !re || (raddr == ADDR_W'(NOPRegAddr))) begin
      return DATA_W'(ZeroWord);
    end else if ((ex_we_i == WriteEnable) && (ex_waddr_i == raddr)) begin
      return ex_wdata_i;
    end else if ((mem_we_q == WriteEnable) && (mem_waddr_q == raddr)) begin
      return mem_wdata_q;
    end else begin
      return rf_data;
    end
  endfunction

  always_comb begin
    rdata1_o = forward(re1_i, raddr1_i, rf_rdata1);
    rdata2_o = forward(re2_i, raddr2_i, rf_rdata2);
  end

  assign wb_we_o    = wb_we_q;
  assign wb_waddr_o = wb_waddr_q;
  assign wb_wdata_o = wb_wdata_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed pipeline scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the write-back path.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ex_waddr;
  logic        ex_we;
  logic [31:0] ex_wdata;
  logic        stall;
  logic        flush;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } trip_t;

  localparam trip_t Bubble = '{we: 1'b0, addr: 5'd0, data: 32'd0};

  logic [31:0] mRegs [32];
  trip_t       mMem;
  trip_t       mWb;

  wb_regfile dut (
    .clk        (clk),
    .rst        (rst),
    .ex_waddr_i (ex_waddr),
    .ex_we_i    (ex_we),
    .ex_wdata_i (ex_wdata),
    .stall_i    (stall),
    .flush_i    (flush),
    .re1_i      (re1),
    .raddr1_i   (raddr1),
    .rdata1_o   (rdata1),
    .re2_i      (re2),
    .raddr2_i   (raddr2),
    .rdata2_o   (rdata2),
    .wb_we_o    (wb_we),
    .wb_waddr_o (wb_waddr),
    .wb_wdata_o (wb_wdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Read rules in priority order, youngest producer first.
  function automatic logic [31:0] modelRead(input logic re, input logic [4:0] ra);
    if (rst || !re || ra == 5'd0) return 32'd0;
    if (ex_we && ex_waddr == ra)  return ex_wdata;
    if (mMem.we && mMem.addr == ra) return mMem.data;
    if (mWb.we && mWb.addr == ra) return mWb.data;
    return mRegs[ra];
  endfunction

  task automatic applyStimulus(input logic r, input logic fl, input logic st,
                               input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic e1, input logic [4:0] a1,
                               input logic e2, input logic [4:0] a2);
    rst = r; flush = fl; stall = st;
    ex_we = we; ex_waddr = wa; ex_wdata = wd;
    re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
    #3;
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, ".rd1"}, rdata1, modelRead(re1, raddr1));
    checkOutput({tag, ".rd2"}, rdata2, modelRead(re2, raddr2));
    checkOutput({tag, ".wbwe"}, {31'd0, wb_we}, {31'd0, mWb.we});
    checkOutput({tag, ".wbaddr"}, {27'd0, wb_waddr}, {27'd0, mWb.addr});
    checkOutput({tag, ".wbdata"}, wb_wdata, mWb.data);
  endtask

  // Advance one clock and apply the stage/array rules to the model.
  task automatic tick();
    trip_t oldMem;
    @(posedge clk);
    oldMem = mMem;
    if (rst) begin
      for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;
      mMem = Bubble;
      mWb  = Bubble;
    end else begin
      if (mWb.we && mWb.addr != 5'd0) mRegs[mWb.addr] = mWb.data;
      if (flush)       mMem = Bubble;
      else if (!stall) mMem = '{we: ex_we, addr: ex_waddr, data: ex_wdata};
      mWb = (flush || stall) ? Bubble : oldMem;
    end
    #1;
  endtask

  task automatic idleCycle(input string tag, input logic [4:0] a1, input logic [4:0] a2);
    applyStimulus(0, 0, 0, 0, 5'd0, 32'd0, 1, a1, 1, a2);
    checkModel(tag);
    tick();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;
    mMem = Bubble;
    mWb  = Bubble;
    #1;

    // Initial reset: stage contents are unknown until the first edge.
    applyStimulus(1, 0, 0, 0, 5'd0, 32'd0, 1, 5'd1, 1, 5'd2);
    checkOutput("init.rd1", rdata1, 32'd0);
    checkOutput("init.rd2", rdata2, 32'd0);
    tick();
    idleCycle("postreset", 5'd1, 5'd31);

    // Back-to-back writes to r3.
    applyStimulus(0, 0, 0, 1, 5'd3, 32'h11111111, 1, 5'd3, 1, 5'd4);
    checkModel("b2b.n");
    checkOutput("b2b.n.ex", rdata1, 32'h11111111);
    tick();
    applyStimulus(0, 0, 0, 1, 5'd3, 32'h22222222, 1, 5'd3, 1, 5'd3);
    checkModel("b2b.n1");
    checkOutput("b2b.n1.ex", rdata1, 32'h22222222);
    tick();
    applyStimulus(0, 0, 0, 0, 5'd0, 32'd0, 1, 5'd3, 0, 5'd3);
    checkModel("b2b.n2");
    checkOutput("b2b.n2.mem", rdata1, 32'h22222222);
    tick();
    idleCycle("b2b.n3", 5'd3, 5'd0);
    applyStimulus(0, 0, 0, 0, 5'd0, 32'd0, 1, 5'd3, 1, 5'd3);
    checkModel("b2b.n4");
    checkOutput("b2b.n4.arr", rdata2, 32'h22222222);
    tick();

    // r0 is never writable.
    applyStimulus(0, 0, 0, 1, 5'd0, 32'hDEADBEEF, 1, 5'd0, 1, 5'd0);
    checkModel("r0.n");
    checkOutput("r0.n.rd", rdata1, 32'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      idleCycle("r0.later", 5'd0, 5'd3);
      checkOutput("r0.later.rd", rdata1, 32'd0);
    end

    // Stall holds MEM and sends bubbles into WB.
    applyStimulus(0, 0, 0, 1, 5'd5, 32'hA5A5A5A5, 1, 5'd5, 1, 5'd6);
    checkModel("stall.n");
    tick();
    applyStimulus(0, 0, 1, 1, 5'd6, 32'h66666666, 1, 5'd5, 1, 5'd6);
    checkModel("stall.n1");
    checkOutput("stall.n1.rd5", rdata1, 32'hA5A5A5A5);
    tick();
    applyStimulus(0, 0, 1, 0, 5'd0, 32'd0, 1, 5'd5, 1, 5'd6);
    checkModel("stall.n2");
    checkOutput("stall.n2.wbwe", {31'd0, wb_we}, 32'd0);
    checkOutput("stall.n2.rd6", rdata2, 32'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 5'd0, 32'd0, 1, 5'd5, 1, 5'd6);
    checkModel("stall.n3");
    checkOutput("stall.n3.wbwe", {31'd0, wb_we}, 32'd0);
    checkOutput("stall.n3.rd5", rdata1, 32'hA5A5A5A5);
    tick();
    applyStimulus(0, 0, 0, 0, 5'd0, 32'd0, 1, 5'd5, 1, 5'd6);
    checkModel("stall.n4");
    checkOutput("stall.n4.wbwe", {31'd0, wb_we}, 32'd1);
    checkOutput("stall.n4.wbaddr", {27'd0, wb_waddr}, 32'd5);
    tick();
    idleCycle("stall.n5", 5'd5, 5'd6);
    checkOutput("stall.n5.arr", rdata1, 32'hA5A5A5A5);

    // Flush over stall drops the held r7 write.
    applyStimulus(0, 0, 0, 1, 5'd7, 32'h00001234, 1, 5'd7, 1, 5'd0);
    checkModel("flush.pre");
    tick();
    for (int k = 0; k < 3; k++) idleCycle("flush.retire", 5'd7, 5'd5);
    applyStimulus(0, 0, 0, 1, 5'd7, 32'h00000007, 1, 5'd7, 1, 5'd7);
    checkModel("flush.n");
    tick();
    applyStimulus(0, 1, 1, 0, 5'd0, 32'd0, 1, 5'd7, 1, 5'd7);
    checkModel("flush.n1");
    tick();
    for (int k = 0; k < 3; k++) begin
      idleCycle("flush.after", 5'd7, 5'd5);
      checkOutput("flush.after.rd7", rdata1, 32'h00001234);
    end

    // Read-enable gating per port.
    applyStimulus(0, 0, 0, 1, 5'd9, 32'h99999999, 1, 5'd9, 1, 5'd9);
    checkModel("dual.w");
    tick();
    for (int k = 0; k < 3; k++) idleCycle("dual.retire", 5'd9, 5'd9);
    applyStimulus(0, 0, 0, 0, 5'd0, 32'd0, 0, 5'd9, 1, 5'd9);
    checkModel("dual.gate");
    checkOutput("dual.gate.rd1", rdata1, 32'd0);
    checkOutput("dual.gate.rd2", rdata2, 32'h99999999);
    tick();

    // Reset with a write in flight.
    applyStimulus(0, 0, 0, 1, 5'd10, 32'hAAAA0010, 1, 5'd10, 1, 5'd9);
    checkModel("rstfly.n");
    tick();
    applyStimulus(1, 0, 0, 0, 5'd0, 32'd0, 1, 5'd10, 1, 5'd9);
    checkModel("rstfly.n1");
    checkOutput("rstfly.n1.rd10", rdata1, 32'd0);
    tick();
    for (int k = 0; k < 3; k++) begin
      idleCycle("rstfly.after", 5'd10, 5'd9);
      checkOutput("rstfly.after.rd10", rdata1, 32'd0);
      checkOutput("rstfly.after.rd9", rdata2, 32'd0);
    end

    // Randomized traffic concentrated on a few registers to exercise forwarding.
    for (int k = 0; k < 400; k++) begin
      applyStimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 9)), $urandom(),
                    ($urandom_range(0, 7) != 0), 5'($urandom_range(0, 9)),
                    ($urandom_range(0, 7) != 0), 5'($urandom_range(0, 31)));
      checkModel("rand");
      tick();
    end

    // Reset after random writes clears every register.
    applyStimulus(1, 0, 0, 0, 5'd0, 32'd0, 1, 5'd1, 1, 5'd2);
    checkModel("finalrst");
    tick();
    for (int k = 0; k < 16; k++) begin
      idleCycle("sweep", 5'(2 * k + 1), 5'(2 * k + 2));
      checkOutput("sweep.rd1", rdata1, 32'd0);
      checkOutput("sweep.rd2", rdata2, 32'd0);
      checkOutput("sweep.wbwe", {31'd0, wb_we}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
